// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath widths, opcode encoding and flag bit positions.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_SHL   = 4'b0110,
    OP_SHR   = 4'b0111,
    OP_INC   = 4'b1000,
    OP_DEC   = 4'b1001,
    OP_CMP   = 4'b1010,
    OP_ROL   = 4'b1011,
    OP_ROR   = 4'b1100,
    OP_PASSA = 4'b1101,
    OP_PASSB = 4'b1110,
    OP_ZERO  = 4'b1111
  } alu_op_e;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  // Gathers the four ALU flag wires into the {C,Z,V,N} vector carried downstream.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic z,
                                                   input logic v, input logic n);
    logic [FLAG_W-1:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_Z] = z;
    f[FLG_V] = v;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module alu_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command FIFO -> registered ALU issue stage -> registered result stage with valid/ready backpressure.
// Build option ALU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags accumulating flags of consumed results.
module alu_cmd_issue #(
  parameter int DATA_W     = alu_pkg::DATA_W,
  parameter int OP_W       = alu_pkg::OP_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OP_W-1:0]               in_opcode,
  input  logic [DATA_W-1:0]             in_a,
  input  logic [DATA_W-1:0]             in_b,
  output logic [OP_W-1:0]               alu_opcode,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic                          alu_carry,
  input  logic                          alu_zero,
  input  logic                          alu_overflow,
  input  logic                          alu_negative,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_result,
  output logic [3:0]                    out_flags,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic                          sticky_clr,
  output logic [3:0]                    sticky_flags
`endif
);

  import alu_pkg::*;

  localparam int CMD_W = OP_W + 2 * DATA_W;

  logic [CMD_W-1:0]  fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              out_adv, iss_adv;
  logic [FLAG_W-1:0] alu_flags;

  logic              iss_v_q, iss_v_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [FLAG_W-1:0] out_flags_q, out_flags_d;

  // in_ready looks only at occupancy, so a same-cycle pop never frees a slot for a push.
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign fifo_wdata = {in_opcode, in_a, in_b};

  assign out_adv = !out_valid_q || out_ready;
  assign iss_adv = !iss_v_q || out_adv;
  assign pop     = iss_adv && !fifo_empty;

  assign alu_flags = pack_flags(alu_carry, alu_zero, alu_overflow, alu_negative);

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    iss_v_d      = iss_v_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;

    // A bubble in the issue stage clears out_valid but leaves the captured data untouched.
    if (out_adv) begin
      out_valid_d = iss_v_q;
      if (iss_v_q) begin
        out_result_d = alu_result;
        out_flags_d  = alu_flags;
      end
    end

    if (iss_adv) begin
      iss_v_d = !fifo_empty;
      if (!fifo_empty) {alu_op_d, alu_a_d, alu_b_d} = fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      iss_v_q      <= iss_v_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [FLAG_W-1:0] sticky_q, sticky_d;

  // Clear has priority over accumulating the flags of a result consumed in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)                    sticky_d = '0;
    else if (out_valid_q && out_ready) sticky_d = sticky_q | out_flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: a behavioural ALU answers the issue stage, and a
// queue scoreboard predicts every consumed result from the commands the block accepted.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DW    = 16;
  localparam int OW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [OW-1:0] in_opcode;
  logic [DW-1:0] in_a, in_b;
  logic [OW-1:0] alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_carry, alu_zero, alu_overflow, alu_negative;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [3:0]    out_flags;
  logic [2:0]    fifo_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic          sticky_clr;
  logic [3:0]    sticky_flags;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc_n    = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  int          got_cyc[$];

  always #5 clk = ~clk;

  alu_cmd_issue #(.DATA_W(DW), .OP_W(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_negative (alu_negative),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .fifo_count   (fifo_count)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  // Behavioural 16-bit ALU: returns {result, C, Z, V, N}.
  function automatic logic [19:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                     v = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB, OP_CMP: begin r = a - b; c = (a < b);
                     v = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  begin r = {a[14:0], 1'b0}; c = a[15]; end
      OP_SHR:  begin r = {1'b0, a[15:1]}; c = a[0]; end
      OP_INC:  begin w = {1'b0, a} + 17'd1; r = w[15:0]; c = w[16]; v = (a == 16'h7FFF); end
      OP_DEC:  begin r = a - 16'd1; c = (a == 16'h0000); v = (a == 16'h8000); end
      OP_ROL:  r = {a[14:0], a[15]};
      OP_ROR:  r = {a[0], a[15:1]};
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default: r = 16'h0000;
    endcase
    return {r, c, (r == 16'h0000), v, r[15]};
  endfunction

  logic [19:0] alu_ret;
  assign alu_ret      = alu_eval(alu_opcode, alu_a, alu_b);
  assign alu_result   = alu_ret[19:4];
  assign alu_carry    = alu_ret[3];
  assign alu_zero     = alu_ret[2];
  assign alu_overflow = alu_ret[1];
  assign alu_negative = alu_ret[0];

  // One clock: record accepts/handshakes at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (in_valid && in_ready) exp_q.push_back(alu_eval(in_opcode, in_a, in_b));
    if (out_valid && out_ready) begin
      got_q.push_back({out_result, out_flags});
      got_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic drain(input string name);
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (k < 64 && !(got_q.size() == exp_q.size() && out_valid === 1'b0 && fifo_count == 0)) begin
      cycle();
      k++;
    end
    n_assert++;
    if (k >= 64) begin
      n_fail++;
      $display("FAIL %s_drain: pipeline not empty after %0d cycles (got %0d of %0d results)",
               name, k, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_a = '0; in_b = '0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_assert++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_assert++;
    if ({alu_opcode, alu_a, alu_b} !== 36'h0) begin
      n_fail++; $display("FAIL reset_alu_regs: got %h/%h/%h want 0/0/0", alu_opcode, alu_a, alu_b);
    end
    n_assert++;
    if ({out_result, out_flags} !== 20'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h/%b want 0/0000", out_result, out_flags);
    end
`ifdef ALU_STICKY_FLAGS_EN
    n_assert++;
    if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_sticky: got %b want 0000", sticky_flags); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    clear_sb();
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = OP_ADD; in_a = 16'h7FFF; in_b = 16'h0001;
    cycle();
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL lat_t0: got out_valid=%b count=%0d want 0/1", out_valid, fifo_count);
    end
    cycle();
    n_assert++;
    if (alu_opcode !== OP_ADD || alu_a !== 16'h7FFF || alu_b !== 16'h0001 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_t1_issue: got op=%h a=%h b=%h ov=%b want 0/7fff/0001/0",
                         alu_opcode, alu_a, alu_b, out_valid);
    end
    cycle();
    n_assert++;
    if (out_valid !== 1'b1 || out_result !== 16'h8000 || out_flags !== 4'b0011) begin
      n_fail++; $display("FAIL lat_t2_out: got ov=%b res=%h flags=%b want 1/8000/0011",
                         out_valid, out_result, out_flags);
    end
    drain("lat");
    n_assert++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL lat_count: got %0d results want 1", got_q.size()); end
  endtask

  task automatic test_sub_passb();
    clear_sb();
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = OP_SUB; in_a = 16'h0000; in_b = 16'h0001;
    cycle();
    in_opcode = OP_PASSB; in_a = 16'($urandom); in_b = 16'h0000;
    cycle();
    drain("subpb");
    n_assert++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL subpb_count: got %0d results want 2", got_q.size());
    end else begin
      n_assert++;
      if (got_q[0] !== 20'hFFFF9) begin n_fail++; $display("FAIL subpb_sub: got %h want ffff9", got_q[0]); end
      n_assert++;
      if (got_q[1] !== 20'h00004) begin n_fail++; $display("FAIL subpb_passb: got %h want 00004", got_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    int          k;
    logic [19:0] hold;
    clear_sb();
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_opcode = OP_ADD; in_a = 16'h0011; in_b = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (exp_q.size() > idx) begin
        idx++;
        if (idx < 8) begin in_a = 16'(32'h1000 * idx + 32'h11); in_b = 16'(idx); end
        else in_valid = 1'b0;
      end
    end
    n_assert++;
    if (exp_q.size() != 6) begin n_fail++; $display("FAIL bp_accepted: got %0d want 6", exp_q.size()); end
    n_assert++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: got count=%0d in_ready=%b ov=%b want 4/0/1", fifo_count, in_ready, out_valid);
    end
    hold = {out_result, out_flags};
    n_assert++;
    if (exp_q.size() > 0 && hold !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_head: got %h want %h", hold, exp_q[0]);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_assert++;
      if ({out_result, out_flags} !== hold || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_stable: got %h ov=%b want %h/1", {out_result, out_flags}, out_valid, hold);
      end
    end
    out_ready = 1'b1;
    k = 0;
    while (got_q.size() < 8 && k < 40) begin
      cycle();
      k++;
      if (exp_q.size() > idx) begin
        idx++;
        if (idx < 8) begin in_a = 16'(32'h1000 * idx + 32'h11); in_b = 16'(idx); end
        else in_valid = 1'b0;
      end
    end
    drain("bp");
    n_assert++;
    if (got_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL bp_total: got %0d results of %0d accepted want 8/8", got_q.size(), exp_q.size());
    end
    n_assert++;
    if (got_cyc.size() >= 6 && got_cyc[5] - got_cyc[0] != 5) begin
      n_fail++; $display("FAIL bp_consecutive: first 6 results span %0d cycles want 5", got_cyc[5] - got_cyc[0]);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i] || got_q[i][19:4] !== 16'(32'h1000 * i + 32'h11 + i)) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int maxcnt;
    clear_sb();
    out_ready = 1'b1;
    maxcnt = 0;
    in_valid = 1'b1; in_opcode = OP_INC;
    for (int i = 0; i < 20; i++) begin
      in_a = 16'(i); in_b = 16'($urandom);
      cycle();
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
    end
    drain("b2b");
    n_assert++;
    if (maxcnt > 1) begin n_fail++; $display("FAIL b2b_max_count: got %0d want <=1", maxcnt); end
    n_assert++;
    if (got_q.size() != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", got_q.size()); end
    n_assert++;
    if (got_cyc.size() == 20 && got_cyc[19] - got_cyc[0] != 19) begin
      n_fail++; $display("FAIL b2b_consecutive: 20 results span %0d cycles want 19", got_cyc[19] - got_cyc[0]);
    end
    for (int i = 0; i < got_q.size() && i < 20; i++) begin
      n_assert++;
      if (got_q[i] !== {16'(i + 1), 4'b0000}) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], {16'(i + 1), 4'b0000});
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_opcode = OP_XOR; in_a = 16'($urandom); in_b = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got out_valid=%b want 1", out_valid); end
    #3;
    rst = 1'b1;
    #1;
    n_assert++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || {alu_opcode, alu_a, alu_b} !== 36'h0) begin
      n_fail++; $display("FAIL rmid_async: got ov=%b count=%0d alu=%h/%h/%h want 0/0/0/0/0",
                         out_valid, fifo_count, alu_opcode, alu_a, alu_b);
    end
    clear_sb();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (8) cycle();
    n_assert++;
    if (got_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_stale: got %0d results ov=%b in_ready=%b want 0/0/1",
                         got_q.size(), out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    int          inflight;
    logic        stall;
    logic [19:0] hold;
    clear_sb();
    for (int c = 0; c < 300; c++) begin
      inflight = exp_q.size() - got_q.size();
      n_assert++;
      if (inflight > DEPTH + 2 || (inflight < DEPTH && in_ready !== 1'b1)) begin
        n_fail++; $display("FAIL rnd_occupancy: got in_flight=%0d in_ready=%b", inflight, in_ready);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_opcode = 4'($urandom_range(0, 15));
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      stall     = out_valid && !out_ready;
      hold      = {out_result, out_flags};
      cycle();
      if (stall) begin
        n_assert++;
        if (out_valid !== 1'b1 || {out_result, out_flags} !== hold) begin
          n_fail++; $display("FAIL rnd_stall_stable: got %h ov=%b want %h/1", {out_result, out_flags}, out_valid, hold);
        end
      end
    end
    drain("rnd");
    n_assert++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rnd_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef ALU_STICKY_FLAGS_EN
  task automatic test_sticky();
    int k;
    clear_sb();
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    n_assert++;
    if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL sticky_clear: got %b want 0000", sticky_flags); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = OP_ADD; in_a = 16'hFFFF; in_b = 16'h0002;
    cycle();
    in_opcode = OP_SUB; in_a = 16'h8000; in_b = 16'h0001;
    cycle();
    drain("sticky_cv");
    n_assert++;
    if (sticky_flags !== 4'b1010) begin n_fail++; $display("FAIL sticky_cv: got %b want 1010", sticky_flags); end
    in_valid = 1'b1; in_opcode = OP_PASSA; in_a = 16'h8000; in_b = 16'h0000;
    cycle();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 10) begin cycle(); k++; end
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    n_assert++;
    if (sticky_flags !== 4'b0000 || got_q.size() != 3) begin
      n_fail++; $display("FAIL sticky_clr_wins: got sticky=%b results=%0d want 0000/3", sticky_flags, got_q.size());
    end
    drain("sticky");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_sub_passb();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef ALU_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
Upstream command-issue and result-capture stage for the 16-bit combinational ALU.
- Accepts ALU commands (opcode, A, B) over a valid/ready interface and buffers them in a small FIFO.
- Drives each command to the ALU from a registered issue stage, then registers the ALU result and flags into an output stage with valid/ready backpressure.
- Makes the combinational ALU usable as a fully pipelined, 1-op/cycle unit between sequencer and writeback.

Parameters:
DATA_W, 16, operand/result width; must match the ALU.
OP_W, 4, opcode width.
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  command present.
in_ready  output  1  FIFO can accept; high iff fifo_count < FIFO_DEPTH.
in_opcode  input  OP_W  command opcode.
in_a  input  DATA_W  operand A.
in_b  input  DATA_W  operand B.
alu_opcode  output  OP_W  registered opcode to the ALU.
alu_a  output  DATA_W  registered A to the ALU.
alu_b  output  DATA_W  registered B to the ALU.
alu_result  input  DATA_W  ALU result (combinational return).
alu_carry, alu_zero, alu_overflow, alu_negative  input  1 each  ALU flags.
out_valid  output  1  output register holds a result.
out_ready  input  1  consumer accepts the result.
out_result  output  DATA_W  captured result.
out_flags  output  4  {carry, zero, overflow, negative}; [3]=carry, [0]=negative.
fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, immediate): FIFO pointers and count = 0; issue-valid = 0; out_valid = 0; alu_opcode/alu_a/alu_b = 0; out_result = 0; out_flags = 0. in_ready = 1 once rst deasserts. All in-flight commands are discarded; nothing is emitted for them.
- Three stages: FIFO -> issue register (iss_v) -> output register (out_valid).
- Push: in_valid && in_ready at an edge writes the command at the write pointer.
- in_ready depends only on count. It stays low when full, even if a pop occurs in the same cycle. No combinational in->out path.
- out_adv = !out_valid || out_ready.
  - On out_adv, the output register loads {alu_result, flags} with out_valid = iss_v.
  - When iss_v = 0, out_valid clears and data is don't-care, held unchanged.
- iss_adv = !iss_v || out_adv.
  - On iss_adv: if the FIFO is non-empty, pop the head into alu_* and set iss_v = 1.
  - Otherwise iss_v = 0 and alu_* hold their value.
- Latency: command accepted at edge t -> on ALU inputs after edge t+1 -> out_valid high after edge t+2, assuming an empty pipeline and no backpressure.
- Throughput: 1 command/cycle sustained when out_ready = 1.
- Backpressure: while out_valid && !out_ready, out_result and out_flags are stable. Max accepted-but-unconsumed commands = FIFO_DEPTH + 2.
- Simultaneous push/pop: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH. A push into an empty FIFO is not bypassed.
- Ordering: results emerge strictly in acceptance order.
- Flags are captured verbatim from the ALU. This block does no flag computation.

Optional Feature:
ALU_STICKY_FLAGS_EN
- Defined:
  - Adds input sticky_clr (1) and output sticky_flags (4), reset 0.
  - On each output handshake (out_valid && out_ready), sticky_flags |= out_flags.
  - sticky_clr clears sticky_flags. Clear wins over a same-cycle OR, i.e. the result is 0.
- Undefined: neither port exists; no extra logic.

Decomposition:
- Package alu_pkg:
  - DATA_W and OP_W constants.
  - Opcode constants: OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_XOR=0100, OP_NOT=0101, OP_SHL=0110, OP_SHR=0111, OP_INC=1000, OP_DEC=1001, OP_CMP=1010, OP_ROL=1011, OP_ROR=1100, OP_PASSA=1101, OP_PASSB=1110, OP_ZERO=1111.
  - Flag index constants: FLG_C=3, FLG_Z=2, FLG_V=1, FLG_N=0.
- Sub-module alu_cmd_fifo: generic synchronous FIFO with count, push/pop, full/empty. The issue and output stages stay in the top.

Test Plan:
- Latency: ADD A=0x7FFF B=0x0001 accepted at edge t, out_ready=1 -> out_valid after edge t+2, out_result=0x8000, out_flags=0b0011 (V=1, N=1).
- SUB A=0x0000 B=0x0001 -> out_result=0xFFFF, out_flags=0b1001 (C=1, N=1). Then PASSB B=0x0000 -> 0x0000, out_flags=0b0100 (Z=1).
- Backpressure: out_ready=0, in_valid held high with 8 distinct ADDs -> exactly 6 accepted, fifo_count=4, in_ready=0, output stable. Then out_ready=1 -> 6 results in order on consecutive cycles, then remaining 2.
- Throughput/wrap: 20 back-to-back INCs of A=0..19 with out_ready=1 -> 20 results 1..20 on consecutive cycles; fifo_count never exceeds 1; pointers wrap without loss.
- Reset mid-op: 3 commands in flight, out_ready=0, assert rst asynchronously mid-cycle -> out_valid, fifo_count and alu_* go 0 immediately; after release, no stale result appears.
- ALU_STICKY_FLAGS_EN: results with C, then V, consumed -> sticky_flags=0b1010. sticky_clr in the same cycle as a handshake with N -> sticky_flags=0.
